// File: rtl/bl_pair_fetch_if.sv
// Sample-write, pair-read and status bundle between bl_order_gen, the
// antenna sample source and the bl_pair_fetch store.
interface bl_pair_fetch_if #(
    parameter int N_ANTS     = 8,
    parameter int DATA_WIDTH = 16
);
    localparam int ANT_BITS = $clog2(N_ANTS);

    logic                  din_sync;
    logic                  din_vld;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [ANT_BITS-1:0]   ant_a;
    logic [ANT_BITS-1:0]   ant_b;
    logic                  buf_sel;
    logic                  dout_vld;
    logic [DATA_WIDTH-1:0] dout_a;
    logic [DATA_WIDTH-1:0] dout_b;
    logic [ANT_BITS-1:0]   dout_ant_a;
    logic [ANT_BITS-1:0]   dout_ant_b;
    logic [1:0]            buf_full;
    logic                  ovf;
    logic                  udf;

    modport master (
        output din_sync, din_vld, din, rd_en, ant_a, ant_b, buf_sel,
        input  dout_vld, dout_a, dout_b, dout_ant_a, dout_ant_b,
        input  buf_full, ovf, udf
    );

    modport slave (
        input  din_sync, din_vld, din, rd_en, ant_a, ant_b, buf_sel,
        output dout_vld, dout_a, dout_b, dout_ant_a, dout_ant_b,
        output buf_full, ovf, udf
    );
endinterface

// File: rtl/bl_pair_fetch.sv
// Double-buffered per-channel antenna sample store: one bank fills while
// bl_order_gen reads antenna pairs from the other, with 2-cycle read latency.
module bl_pair_fetch #(
    parameter int N_ANTS     = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    bl_pair_fetch_if.slave bus
);
    localparam int                  ANT_BITS = $clog2(N_ANTS);
    localparam int                  DEPTH    = 2 * N_ANTS;
    localparam logic [ANT_BITS-1:0] LAST_ANT = ANT_BITS'(N_ANTS - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ANT_BITS-1:0]   r_wr_cnt;
    logic                  r_wr_bank;
    logic [1:0]            r_buf_full;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  r_s1_vld;
    logic [ANT_BITS:0]     r_s1_addr_a;
    logic [ANT_BITS:0]     r_s1_addr_b;
    logic [ANT_BITS-1:0]   r_s1_ant_a;
    logic [ANT_BITS-1:0]   r_s1_ant_b;

    logic                  r_dout_vld;
    logic [DATA_WIDTH-1:0] r_dout_a;
    logic [DATA_WIDTH-1:0] r_dout_b;
    logic [ANT_BITS-1:0]   r_dout_ant_a;
    logic [ANT_BITS-1:0]   r_dout_ant_b;

    logic [ANT_BITS-1:0]   w_wr_cnt;
    logic                  w_wr_bank;
    logic [1:0]            w_full_base;
    logic [1:0]            w_buf_full_nxt;
    logic                  w_wr_ok;
    logic                  w_wr_last;
    logic [ANT_BITS:0]     w_wr_addr;
    logic                  w_release;
    logic                  w_rd_udf;

    // A sync pulse realigns the write pointer in the same cycle, so the
    // accompanying sample is judged against the cleared state.
    always_comb begin
        w_wr_cnt       = r_wr_cnt;
        w_wr_bank      = r_wr_bank;
        w_full_base    = r_buf_full;
        if (bus.din_sync) begin
            w_wr_cnt    = {ANT_BITS{1'b0}};
            w_wr_bank   = 1'b0;
            w_full_base = 2'b00;
        end else begin
            w_wr_cnt    = r_wr_cnt;
            w_wr_bank   = r_wr_bank;
            w_full_base = r_buf_full;
        end
        w_wr_ok   = bus.din_vld & ~w_full_base[w_wr_bank];
        w_wr_last = w_wr_ok & (w_wr_cnt == LAST_ANT);
        w_wr_addr = {w_wr_bank, w_wr_cnt};
        w_release = bus.rd_en & (bus.ant_a == LAST_ANT) & (bus.ant_b == LAST_ANT);
        w_rd_udf  = bus.rd_en & ~r_buf_full[bus.buf_sel];

        // Release applied first so a same-cycle fill completion wins.
        w_buf_full_nxt = w_full_base;
        if (w_release) begin
            w_buf_full_nxt[bus.buf_sel] = 1'b0;
        end else begin
            w_buf_full_nxt = w_full_base;
        end
        if (w_wr_last) begin
            w_buf_full_nxt[w_wr_bank] = 1'b1;
        end else begin
            w_buf_full_nxt[w_wr_bank] = w_buf_full_nxt[w_wr_bank];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt   <= {ANT_BITS{1'b0}};
            r_wr_bank  <= 1'b0;
            r_buf_full <= 2'b00;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            r_buf_full <= w_buf_full_nxt;
            if (w_wr_ok) begin
                r_wr_cnt  <= w_wr_last ? {ANT_BITS{1'b0}} : (w_wr_cnt + 1'b1);
                r_wr_bank <= w_wr_last ? ~w_wr_bank : w_wr_bank;
            end else begin
                r_wr_cnt  <= w_wr_cnt;
                r_wr_bank <= w_wr_bank;
            end
            if (bus.din_vld && !w_wr_ok) begin
                r_ovf <= 1'b1;
            end else begin
                r_ovf <= r_ovf;
            end
            if (w_rd_udf) begin
                r_udf <= 1'b1;
            end else begin
                r_udf <= r_udf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[w_wr_addr] <= bus.din;
        end
    end

    // Two-stage read: addresses registered, then both ports read together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld     <= 1'b0;
            r_s1_addr_a  <= {(ANT_BITS + 1){1'b0}};
            r_s1_addr_b  <= {(ANT_BITS + 1){1'b0}};
            r_s1_ant_a   <= {ANT_BITS{1'b0}};
            r_s1_ant_b   <= {ANT_BITS{1'b0}};
            r_dout_vld   <= 1'b0;
            r_dout_a     <= {DATA_WIDTH{1'b0}};
            r_dout_b     <= {DATA_WIDTH{1'b0}};
            r_dout_ant_a <= {ANT_BITS{1'b0}};
            r_dout_ant_b <= {ANT_BITS{1'b0}};
        end else begin
            r_s1_vld   <= bus.rd_en;
            r_dout_vld <= r_s1_vld;
            if (bus.rd_en) begin
                r_s1_addr_a <= {bus.buf_sel, bus.ant_a};
                r_s1_addr_b <= {bus.buf_sel, bus.ant_b};
                r_s1_ant_a  <= bus.ant_a;
                r_s1_ant_b  <= bus.ant_b;
            end else begin
                r_s1_addr_a <= r_s1_addr_a;
                r_s1_addr_b <= r_s1_addr_b;
                r_s1_ant_a  <= r_s1_ant_a;
                r_s1_ant_b  <= r_s1_ant_b;
            end
            if (r_s1_vld) begin
                r_dout_a     <= r_mem[r_s1_addr_a];
                r_dout_b     <= r_mem[r_s1_addr_b];
                r_dout_ant_a <= r_s1_ant_a;
                r_dout_ant_b <= r_s1_ant_b;
            end else begin
                r_dout_a     <= r_dout_a;
                r_dout_b     <= r_dout_b;
                r_dout_ant_a <= r_dout_ant_a;
                r_dout_ant_b <= r_dout_ant_b;
            end
        end
    end

    assign bus.dout_vld   = r_dout_vld;
    assign bus.dout_a     = r_dout_a;
    assign bus.dout_b     = r_dout_b;
    assign bus.dout_ant_a = r_dout_ant_a;
    assign bus.dout_ant_b = r_dout_ant_b;
    assign bus.buf_full   = r_buf_full;
    assign bus.ovf        = r_ovf;
    assign bus.udf        = r_udf;
endmodule

// File: tb/tb_bl_pair_fetch.sv
// Scoreboard bench for bl_pair_fetch: read expectations are queued at issue
// and matched against dout_* whenever dout_vld is seen.
module tb_bl_pair_fetch;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    typedef struct packed {
        logic        cd;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  ia;
        logic [2:0]  ib;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    bl_pair_fetch_if #(.N_ANTS(8), .DATA_WIDTH(16)) bus ();

    bl_pair_fetch #(.N_ANTS(8), .DATA_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.dout_vld === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_dout_vld", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.cd) begin
                    check("dout_a", bus.dout_a, mon_e.a);
                    check("dout_b", bus.dout_b, mon_e.b);
                end
                check("dout_ant_a", bus.dout_ant_a, mon_e.ia);
                check("dout_ant_b", bus.dout_ant_b, mon_e.ib);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] d, input logic sync);
        bus.din      = d;
        bus.din_vld  = 1'b1;
        bus.din_sync = sync;
        @(negedge clk);
        bus.din_vld  = 1'b0;
        bus.din_sync = 1'b0;
    endtask

    task automatic fill(input logic [15:0] base);
        for (int i = 0; i < 8; i++) wr(base + 16'(i), 1'b0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [2:0] b, input logic sel,
                      input logic push, input logic cd,
                      input logic [15:0] ea, input logic [15:0] eb);
        bus.rd_en   = 1'b1;
        bus.ant_a   = a;
        bus.ant_b   = b;
        bus.buf_sel = sel;
        if (push) sb.push_back('{cd: cd, a: ea, b: eb, ia: a, ib: b});
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        bus.din_sync = 1'b0;
        bus.din_vld  = 1'b0;
        bus.din      = 16'h0000;
        bus.rd_en    = 1'b0;
        bus.ant_a    = 3'd0;
        bus.ant_b    = 3'd0;
        bus.buf_sel  = 1'b0;
        idle(2);
        check("rst_dout_vld", bus.dout_vld, 32'd0);
        check("rst_dout_a", bus.dout_a, 32'd0);
        check("rst_dout_b", bus.dout_b, 32'd0);
        check("rst_dout_ant_a", bus.dout_ant_a, 32'd0);
        check("rst_dout_ant_b", bus.dout_ant_b, 32'd0);
        check("rst_buf_full", bus.buf_full, 32'd0);
        check("rst_ovf", bus.ovf, 32'd0);
        check("rst_udf", bus.udf, 32'd0);
        rst = 1'b0;
        idle(1);

        // Basic fill then a read issued in the cycle the flag rises
        fill(16'h0100);
        check("fill0_buf_full", bus.buf_full, 32'd1);
        rd(3'd3, 3'd5, 1'b0, 1'b1, 1'b1, 16'h0103, 16'h0105);
        idle(1);
        check("basic_no_vld_yet", sb.size(), 32'd1);
        idle(2);
        check("basic_drained", sb.size(), 32'd0);
        check("basic_udf", bus.udf, 32'd0);

        // Ping-pong with full order sequence on bank 0
        do_reset();
        fill(16'h0100);
        fill(16'h0200);
        check("pp_full11", bus.buf_full, 32'd3);
        for (int a = 0; a < 8; a++) begin
            for (int b = a; b < 8; b++) begin
                rd(3'(a), 3'(b), 1'b0, 1'b1, 1'b1, 16'h0100 + 16'(a), 16'h0100 + 16'(b));
            end
        end
        check("pp_release", bus.buf_full, 32'd2);
        fill(16'h0300);
        check("pp_refill", bus.buf_full, 32'd3);
        rd(3'd2, 3'd6, 1'b1, 1'b1, 1'b1, 16'h0202, 16'h0206);
        rd(3'd0, 3'd7, 1'b1, 1'b1, 1'b1, 16'h0200, 16'h0207);
        rd(3'd1, 3'd4, 1'b0, 1'b1, 1'b1, 16'h0301, 16'h0304);
        idle(3);
        check("pp_udf", bus.udf, 32'd0);
        check("pp_ovf", bus.ovf, 32'd0);

        // Overflow: 24 writes, nothing read
        do_reset();
        for (int k = 0; k < 24; k++) begin
            if (k < 8)       wr(16'h0100 + 16'(k), 1'b0);
            else if (k < 16) wr(16'h0200 + 16'(k - 8), 1'b0);
            else             wr(16'h0F00 + 16'(k), 1'b0);
            if (k == 15) check("ovf_after16", bus.ovf, 32'd0);
            if (k == 16) check("ovf_after17", bus.ovf, 32'd1);
        end
        check("ovf_full", bus.buf_full, 32'd3);
        rd(3'd2, 3'd6, 1'b0, 1'b1, 1'b1, 16'h0102, 16'h0106);
        rd(3'd0, 3'd7, 1'b1, 1'b1, 1'b1, 16'h0200, 16'h0207);
        idle(3);
        check("ovf_udf", bus.udf, 32'd0);

        // Underrun on empty bank
        do_reset();
        rd(3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
        check("udf_set", bus.udf, 32'd1);
        idle(3);
        check("udf_drained", sb.size(), 32'd0);
        check("udf_buf_full", bus.buf_full, 32'd0);
        check("udf_ovf", bus.ovf, 32'd0);

        // Sync mid-fill realigns to bank 0, antenna 0
        do_reset();
        for (int i = 0; i < 5; i++) wr(16'h0500 + 16'(i), 1'b0);
        wr(16'h0A00, 1'b1);
        for (int i = 1; i < 8; i++) wr(16'h0A00 + 16'(i), 1'b0);
        check("sync_full01", bus.buf_full, 32'd1);
        rd(3'd0, 3'd4, 1'b0, 1'b1, 1'b1, 16'h0A00, 16'h0A04);
        rd(3'd5, 3'd6, 1'b0, 1'b1, 1'b1, 16'h0A05, 16'h0A06);
        fill(16'h0B00);
        check("sync_full11", bus.buf_full, 32'd3);
        rd(3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 16'h0B02, 16'h0B03);
        idle(3);
        check("sync_ovf", bus.ovf, 32'd0);

        // Reset one cycle into a read: the pair must never appear
        do_reset();
        fill(16'h0C00);
        rd(3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b1;
        #1;
        check("rstrd_vld_async", bus.dout_vld, 32'd0);
        check("rstrd_full_async", bus.buf_full, 32'd0);
        idle(1);
        rst = 1'b0;
        idle(4);
        check("rstrd_buf_full", bus.buf_full, 32'd0);
        check("rstrd_ovf", bus.ovf, 32'd0);
        check("rstrd_udf", bus.udf, 32'd0);
        check("rstrd_dout_vld", bus.dout_vld, 32'd0);

        check("sb_empty_end", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
